// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM state encoding and latched transfer mode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// FIFO-side handshake of the shift engine: TX FIFO read port and RX FIFO write port.
interface spi_shift_engine_if #(
    parameter int DW = 8
);
    logic          tx_empty;
    logic [DW-1:0] tx_dout;
    logic          tx_re;
    logic          rx_full;
    logic [DW-1:0] rx_din;
    logic          rx_we;

    // master is the engine; slave is the FIFO pair it sits between
    modport master (input tx_empty, tx_dout, rx_full, output tx_re, rx_din, rx_we);
    modport slave  (output tx_empty, tx_dout, rx_full, input tx_re, rx_din, rx_we);
endinterface

// File: rtl/spi_clkgen.sv
// SCK timing: half-period divider plus SCK edge counter, producing per-edge strobes.
module spi_clkgen #(
    parameter int DW    = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             first_edge,
    output logic             last_edge
);
    localparam int             ECW      = $clog2(2*DW+1);
    localparam logic [ECW-1:0] LAST_IDX = ECW'(2*DW-1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [ECW-1:0]   ecnt;
    logic             tick;

    // ecnt holds the number of edges already made, so edge ecnt+1 is odd (leading) when ecnt is even
    assign tick       = run && (cnt == '0);
    assign lead_edge  = tick && !ecnt[0];
    assign trail_edge = tick &&  ecnt[0];
    assign first_edge = tick && (ecnt == '0);
    assign last_edge  = tick && (ecnt == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= '0;
            ecnt  <= '0;
        end else if (clr) begin
            cnt   <= '0;
            ecnt  <= '0;
        end else if (load) begin
            cnt   <= div;
            div_q <= div;
            ecnt  <= '0;
        end else if (tick) begin
            cnt   <= div_q;
            ecnt  <= ecnt + 1'b1;
        end else if (run) begin
            cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master serializer: pops TX FIFO bytes, shifts them out on MOSI in any CPOL/CPHA
// mode while capturing MISO, and pushes the received byte into the RX FIFO.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DIV_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIV_W-1:0]    div,
    spi_shift_engine_if.master  fifo,
    output logic                sck_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic                busy,
    output logic                done
);
    spi_state_t    state, state_nxt;
    spi_mode_t     mode_q;
    logic [DW-1:0] shreg, rxsh, rx_din_q, rx_nxt;
    logic          start, push;
    logic          lead_edge, trail_edge, first_edge, last_edge;
    logic          sample, shift;

    spi_clkgen #(.DW(DW), .DIV_W(DIV_W)) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (start),
        .run        (state == SHIFT),
        .div        (div),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .first_edge (first_edge),
        .last_edge  (last_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: if (en && !fifo.tx_empty && !fifo.rx_full) begin
                start     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: if (last_edge) state_nxt = DONE;
            DONE: begin
                push      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // an abort or reset suppresses both FIFO strobes in the same cycle
        if (clr || rst) begin
            state_nxt = IDLE;
            start     = 1'b0;
            push      = 1'b0;
        end
    end

    // CPHA=1 skips the shift on edge 1 because the first bit is already on MOSI
    assign sample = mode_q.cpha ? trail_edge : lead_edge;
    assign shift  = mode_q.cpha ? (lead_edge && !first_edge) : trail_edge;
    assign rx_nxt = {rxsh[DW-2:0], miso_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_o    <= 1'b0;
            shreg    <= '0;
            rxsh     <= '0;
            rx_din_q <= '0;
            mode_q   <= '0;
        end else if (clr) begin
            sck_o <= mode_q.cpol;
        end else begin
            if (state == IDLE) begin
                sck_o <= cpol;
                if (start) begin
                    shreg       <= fifo.tx_dout;
                    rxsh        <= '0;
                    mode_q.cpol <= cpol;
                    mode_q.cpha <= cpha;
                end
            end
            if (lead_edge || trail_edge) sck_o <= ~sck_o;
            if (shift)                   shreg <= {shreg[DW-2:0], 1'b0};
            if (sample)                  rxsh  <= rx_nxt;
            if (last_edge)               rx_din_q <= sample ? rx_nxt : rxsh;
        end
    end

    assign fifo.tx_re  = start;
    assign fifo.rx_we  = push;
    assign fifo.rx_din = rx_din_q;
    assign done        = push;
    assign busy        = (state != IDLE);
    assign mosi_o      = shreg[DW-1];

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: a TX FIFO model feeds random bytes, an SPI slave
// monitor decodes MOSI from SCK, and expected RX words/latencies are queued per transfer.
module tb_spi_shift_engine;
    localparam int DW    = 8;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst, clr, en, cpol, cpha;
    logic [DIV_W-1:0] div;
    logic             sck, mosi, busy, done;
    int               miso_mode;   // 0 loopback, 1 tied high, 2 tied low, 3 inverted loopback
    wire              miso = (miso_mode == 0) ? mosi :
                             (miso_mode == 1) ? 1'b1 :
                             (miso_mode == 2) ? 1'b0 : ~mosi;

    spi_shift_engine_if #(.DW(DW)) fifo_bus ();

    spi_shift_engine #(.DW(DW), .DIV_W(DIV_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .cpol   (cpol),
        .cpha   (cpha),
        .div    (div),
        .fifo   (fifo_bus),
        .sck_o  (sck),
        .mosi_o (mosi),
        .miso_i (miso),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         due;
        logic       cpol;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         starts_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] model_rx(input logic [7:0] tx, input int mm);
        case (mm)
            0:       return tx;
            1:       return 8'hFF;
            2:       return 8'h00;
            default: return ~tx;
        endcase
    endfunction

    task automatic fifo_refresh();
        fifo_bus.tx_empty = (tx_q.size() == 0);
        fifo_bus.tx_dout  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    endtask

    // Monitor: TX FIFO pop side, SPI slave decode of MOSI, and RX push scoreboard
    logic       sck_prev = 1'b0, x_cpol = 1'b0, x_cpha = 1'b0;
    int         edges = 0, nbits = 0;
    logic [7:0] cap = 8'h00;
    bit         pop_pend = 1'b0;

    always @(negedge clk) begin
        if (pop_pend) begin
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            pop_pend = 1'b0;
            fifo_refresh();
        end
        if (!rst) begin
            if (sck !== sck_prev) begin
                edges++;
                if ((sck != x_cpol) ^ x_cpha) begin
                    cap = {cap[6:0], mosi};
                    nbits++;
                end
            end
            sck_prev = sck;

            if (fifo_bus.tx_re) begin
                check(!fifo_bus.tx_empty && !fifo_bus.rx_full && !clr && en, "pop_legal",
                      {fifo_bus.tx_empty, fifo_bus.rx_full, clr, en}, 4'b0001);
                if (tx_q.size() != 0) begin
                    exp_q.push_back('{tx: tx_q[0], rx: model_rx(tx_q[0], miso_mode),
                                      due: cyc + 2*DW*(int'(div) + 1) + 1, cpol: cpol});
                    pop_pend = 1'b1;
                end
                x_cpol = cpol;
                x_cpha = cpha;
                edges  = 0;
                nbits  = 0;
                starts_q.push_back(cyc);
            end

            if (fifo_bus.rx_we) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_push", fifo_bus.rx_din, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(fifo_bus.rx_din == e.rx, "rx_data", fifo_bus.rx_din, e.rx);
                    check(cyc == e.due, "rx_latency", cyc, e.due);
                    check(cap == e.tx && nbits == DW, "mosi_bits", {nbits, cap}, {DW, e.tx});
                    check(edges == 2*DW, "sck_edges", edges, 2*DW);
                    check(sck == e.cpol, "sck_idle_at_done", sck, e.cpol);
                    check(done == 1'b1, "done_with_push", done, 1);
                end
            end else if (done) begin
                check(1'b0, "done_without_push", done, 0);
            end
        end
    end

    // Stimulus helpers: inputs change 2 time units after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        tx_q.push_back(b);
        fifo_refresh();
    endtask

    task automatic set_mode(input logic [1:0] m, input logic [DIV_W-1:0] d, input int mm);
        cpol      = m[1];
        cpha      = m[0];
        div       = d;
        miso_mode = mm;
        tick(2);
    endtask

    task automatic wait_done(input bit need_drain, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || (need_drain && tx_q.size() != 0)) && n < budget) begin
            tick(1);
            n++;
        end
        check(n < budget, "drain_timeout", n, budget);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            tick(1);
            n++;
        end
        check(n < budget, "start_timeout", n, budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({sck, mosi, busy, done, fifo_bus.tx_re, fifo_bus.rx_we} == 6'b0,
              {tag, "_ctrl"}, {sck, mosi, busy, done, fifo_bus.tx_re, fifo_bus.rx_we}, 0);
        check(fifo_bus.rx_din == 8'h00, {tag, "_rx_din"}, fifo_bus.rx_din, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; cpol = 1'b0; cpha = 1'b0; div = '0;
        miso_mode = 0;
        fifo_bus.rx_full = 1'b0;
        fifo_refresh();
        tick(3);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        en  = 1'b1;

        // mode 0, div 0, loopback
        set_mode(2'b00, 8'd0, 0);
        push(8'hA5);
        wait_done(1'b1, 200);

        // mode 3, div 2, MISO high
        set_mode(2'b11, 8'd2, 1);
        push(8'h3C);
        wait_done(1'b1, 300);

        // back-to-back pair
        set_mode(2'b00, 8'd0, 0);
        push(8'h01);
        push(8'h80);
        wait_done(1'b1, 300);
        check(starts_q.size() >= 2 &&
              starts_q[starts_q.size()-1] - starts_q[starts_q.size()-2] == 2*DW + 2,
              "b2b_gap", starts_q[starts_q.size()-1] - starts_q[starts_q.size()-2], 2*DW + 2);

        // RX full blocks start; release pops in the same cycle
        fifo_bus.rx_full = 1'b1;
        push(8'h55);
        tick(20);
        check(tx_q.size() == 1 && !busy, "held_when_full", tx_q.size(), 1);
        fifo_bus.rx_full = 1'b0;
        #1 check(fifo_bus.tx_re == 1'b1, "pop_after_full", fifo_bus.tx_re, 1);
        wait_done(1'b1, 200);

        // clr at SCK edge 5, then a clean transfer
        set_mode(2'b01, 8'd1, 3);
        push(8'hC3);
        wait_busy(10);
        tick(5*2 - 1);
        clr = 1'b1;
        exp_q.delete();
        tick(1);
        clr = 1'b0;
        #1 check(!busy, "clr_idle", busy, 0);
        check(sck == 1'b0, "clr_sck_cpol", sck, 0);
        tick(40);
        push(8'h96);
        wait_done(1'b1, 200);

        // clr while idle with data pending suppresses the pop
        en = 1'b0;
        push(8'h77);
        tick(1);
        clr = 1'b1;
        en  = 1'b1;
        #1 check(fifo_bus.tx_re == 1'b0, "no_pop_in_clr", fifo_bus.tx_re, 0);
        tick(1);
        clr = 1'b0;
        wait_done(1'b1, 200);

        // asynchronous reset mid-SHIFT
        set_mode(2'b10, 8'd3, 0);
        push(8'h5A);
        wait_busy(10);
        tick(20);
        rst = 1'b1;
        exp_q.delete();
        #1 check_reset_outputs("rst_mid_shift");
        tick(2);
        rst = 1'b0;

        // cpol change mid-transfer is ignored
        set_mode(2'b01, 8'd1, 0);
        push(8'hE7);
        wait_busy(10);
        tick(5);
        cpol = 1'b1;
        wait_done(1'b1, 200);

        // en dropped mid-transfer: byte completes, next stays queued
        set_mode(2'b10, 8'd0, 2);
        push(8'h11);
        push(8'h22);
        wait_busy(10);
        en = 1'b0;
        wait_done(1'b0, 200);
        tick(5);
        check(tx_q.size() == 1, "en_drop_hold", tx_q.size(), 1);
        en = 1'b1;
        wait_done(1'b1, 200);

        // maximum divisor
        set_mode(2'b10, 8'hFF, 3);
        push(8'h0F);
        wait_done(1'b1, 2*DW*256 + 100);

        // randomized modes, divisors, MISO sources and burst lengths
        for (int i = 0; i < 16; i++) begin
            int d, nb;
            d  = $urandom_range(0, 4);
            if (d == 4) d = 7;
            nb = $urandom_range(1, 3);
            set_mode(2'($urandom_range(0, 3)), DIV_W'(d), $urandom_range(0, 3));
            for (int j = 0; j < nb; j++) push(8'($urandom_range(0, 255)));
            wait_done(1'b1, nb*(2*DW*(d + 1) + 2) + 50);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
